multi_ch_signal_stretcher: RTL and testbench
============================================

// Module: multi_ch_signal_stretcher
// PURPOSE
//  N-channel trigger pulse stretcher for the minimum-trigger path. Each channel extends its
//  input pulse by a programmable number of cycles after the input falls, with optional
//  retrigger and a programmable dead time. Sits between the per-channel discriminators and
//  the trigger logic. Also provides a registered OR of all channel outputs.
// PARAMETERS
//  N_CH        8   number of independent channels
//  LEN_WIDTH   5   width of each extend-length and dead-time field (max 2^LEN_WIDTH-1)
// PORTS
//  CLK           in   1               clock
//  RESET         in   1               synchronous, active-high reset
//  CFG_LOAD      in   1               1-cycle strobe: latch EXTEND_LEN/DEAD_LEN/RETRIG_EN
//  EXTEND_LEN    in   N_CH*LEN_WIDTH  per-channel extension L; ch i at [i*LEN_WIDTH +: LEN_WIDTH]
//  DEAD_LEN      in   LEN_WIDTH       dead time D (cycles), common to all channels
//  RETRIG_EN     in   1               1 = input high during HOLD re-arms; 0 = fixed-length window
//  SIG_IN        in   N_CH            raw per-channel signals, synchronous to CLK
//  SIG_OUT       out  N_CH            stretched signals, registered
//  SIG_OR        out  1               OR of next-cycle SIG_OUT bits, registered (aligned with SIG_OUT)
// BEHAVIOUR
//  Config: shadow registers load while RESET=1 and on CFG_LOAD=1 (RESET dominates). New values
//   take effect on the cycle after loading; a HOLD/DEAD count already running keeps its loaded count.
//  Per-channel FSM, state and LEN_WIDTH-bit down-counter cnt:
//   IDLE:   SIG_IN=1 -> ACTIVE.
//   ACTIVE: SIG_IN=1 -> stay. SIG_IN=0: L>0 -> HOLD, cnt=L-1; L=0 -> (D>0 ? DEAD,cnt=D-1 : IDLE).
//   HOLD:   RETRIG_EN=1 and SIG_IN=1 -> ACTIVE (pulses merge).
//           else cnt>0 -> cnt-1; cnt=0 -> (D>0 ? DEAD,cnt=D-1 : IDLE). RETRIG_EN=0: SIG_IN ignored.
//   DEAD:   SIG_IN ignored; cnt>0 -> cnt-1; cnt=0 -> IDLE. Level still high at IDLE -> ACTIVE
//           next cycle (no edge required).
//  SIG_OUT[i] is a flop of (next_state in {ACTIVE,HOLD}): 1-cycle latency from the first high
//   sample. Input high for W cycles from an idle channel -> SIG_OUT high for exactly W+L cycles.
//  Within the ACTIVE/HOLD/DEAD sequence, SIG_OUT low for exactly D cycles between windows.
//  SIG_OR registered from OR of the same next-state decodes; never lags SIG_OUT.
//  Channels fully independent; no inter-channel priority or shared counters.
//  Reset: all FSMs IDLE, cnt=0, SIG_OUT=0, SIG_OR=0 on the cycle after RESET is sampled high.
//   Reset mid-pulse truncates immediately. First sample after reset release uses freshly latched config.
//  Arithmetic: counters never wrap; cnt only decrements while >0. L and D at all-ones are legal.
//  Simultaneous: CFG_LOAD in the same cycle as a HOLD/DEAD entry loads cnt from the OLD shadow value.
// TESTING
//  1. L=4,D=0,RETRIG=1; ch0 high 1 cycle -> SIG_OUT[0] high 5 cycles starting 1 cycle later; SIG_OR identical.
//  2. L=0,D=0 -> SIG_OUT = SIG_IN delayed 1 cycle for random stimulus on all 8 channels.
//  3. L=6,RETRIG=1; pulses 1 cycle at t=0 and t=4 -> one merged output, high 11 cycles from t=1.
//  4. L=6,D=3,RETRIG=0; same stimulus -> output high 7 cycles (t=1..7), 2nd pulse ignored, then low 3.
//  5. L=31,D=31 all ones; input held high 40 cycles -> high 71 cycles, low 31, then high again (level still high).
//  6. RESET asserted mid-HOLD with new EXTEND_LEN; CFG_LOAD during HOLD -> output 0 next cycle;
//     in-progress count unaffected by CFG_LOAD; next pulse uses new L.

Source files
------------

// File: rtl/multi_ch_signal_stretcher.sv
// Per-channel trigger pulse stretcher with retrigger and dead time, plus registered OR of all windows.
// Latency: 1 cycle from first high sample to SIG_OUT/SIG_OR; no backpressure, every cycle is consumed.
module multi_ch_signal_stretcher #(
    parameter int N_CH      = 8,
    parameter int LEN_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      CFG_LOAD,
    input  logic [N_CH*LEN_WIDTH-1:0] EXTEND_LEN,
    input  logic [LEN_WIDTH-1:0]      DEAD_LEN,
    input  logic                      RETRIG_EN,
    input  logic [N_CH-1:0]           SIG_IN,
    output logic [N_CH-1:0]           SIG_OUT,
    output logic                      SIG_OR
);

    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, DEAD} state_t;

    logic [N_CH*LEN_WIDTH-1:0] ext_len_q;
    logic [LEN_WIDTH-1:0]      dead_len_q;
    logic                      retrig_q;

    state_t                    state_q [N_CH];
    state_t                    state_d [N_CH];
    logic [LEN_WIDTH-1:0]      cnt_q   [N_CH];
    logic [LEN_WIDTH-1:0]      cnt_d   [N_CH];
    logic [N_CH-1:0]           win_d;

    // Shadow config; a CFG_LOAD coinciding with HOLD/DEAD entry still sees the old values below.
    always_ff @(posedge CLK) begin
        if (RESET || CFG_LOAD) begin
            ext_len_q  <= EXTEND_LEN;
            dead_len_q <= DEAD_LEN;
            retrig_q   <= RETRIG_EN;
        end
    end

    always_comb begin
        win_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (SIG_IN[i]) state_d[i] = ACTIVE;
                end
                ACTIVE: begin
                    if (!SIG_IN[i]) begin
                        if (ext_len_q[i*LEN_WIDTH +: LEN_WIDTH] != '0) begin
                            state_d[i] = HOLD;
                            cnt_d[i]   = ext_len_q[i*LEN_WIDTH +: LEN_WIDTH] - LEN_WIDTH'(1);
                        end else if (dead_len_q != '0) begin
                            state_d[i] = DEAD;
                            cnt_d[i]   = dead_len_q - LEN_WIDTH'(1);
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (retrig_q && SIG_IN[i]) begin
                        state_d[i] = ACTIVE;
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - LEN_WIDTH'(1);
                    end else if (dead_len_q != '0) begin
                        state_d[i] = DEAD;
                        cnt_d[i]   = dead_len_q - LEN_WIDTH'(1);
                    end else begin
                        state_d[i] = IDLE;
                    end
                end
                DEAD: begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - LEN_WIDTH'(1);
                    end else begin
                        // Expiry passes through IDLE in the same cycle so the output gap is exactly D.
                        state_d[i] = SIG_IN[i] ? ACTIVE : IDLE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            win_d[i] = (state_d[i] == ACTIVE) || (state_d[i] == HOLD);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            SIG_OUT <= '0;
            SIG_OR  <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            SIG_OUT <= win_d;
            SIG_OR  <= |win_d;
        end
    end

endmodule

// File: tb/tb_multi_ch_signal_stretcher.sv
// Directed bench for multi_ch_signal_stretcher: vector table plus hand-timed channel-0 sequences.
module tb_multi_ch_signal_stretcher;

    localparam int N_CH = 8;
    localparam int LW   = 5;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               CFG_LOAD;
    logic [N_CH*LW-1:0] EXTEND_LEN;
    logic [LW-1:0]      DEAD_LEN;
    logic               RETRIG_EN;
    logic [N_CH-1:0]    SIG_IN;
    logic [N_CH-1:0]    SIG_OUT;
    logic               SIG_OR;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] sig;
        logic [7:0] exp_out;
        logic       exp_or;
    } vec_t;

    vec_t vec [12];

    multi_ch_signal_stretcher #(.N_CH(N_CH), .LEN_WIDTH(LW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CFG_LOAD   (CFG_LOAD),
        .EXTEND_LEN (EXTEND_LEN),
        .DEAD_LEN   (DEAD_LEN),
        .RETRIG_EN  (RETRIG_EN),
        .SIG_IN     (SIG_IN),
        .SIG_OUT    (SIG_OUT),
        .SIG_OR     (SIG_OR)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic in_rng(input int t, input int a, input int b);
        return (t >= a) && (t <= b);
    endfunction

    // Config is captured by the shadow registers during reset.
    task automatic setup(input int l, input int d, input logic r);
        EXTEND_LEN = {N_CH{LW'(l)}};
        DEAD_LEN   = LW'(d);
        RETRIG_EN  = r;
        SIG_IN     = '0;
        CFG_LOAD   = 1'b0;
        RESET      = 1'b1;
        step();
        step();
        check("reset_out", SIG_OUT, 8'h00);
        check("reset_or", {7'b0, SIG_OR}, 8'h00);
        RESET = 1'b0;
    endtask

    // Channel 0 stimulus/expectation as two intervals each; optional CFG_LOAD or RESET at one cycle.
    task automatic run_seq(input string name, input int n_cyc,
                           input int i1a, input int i1b, input int i2a, input int i2b,
                           input int e1a, input int e1b, input int e2a, input int e2b,
                           input int cfg_t, input int rst_t, input int new_l);
        logic [7:0] exp;
        for (int t = 0; t < n_cyc; t++) begin
            SIG_IN   = {7'b0, in_rng(t, i1a, i1b) || in_rng(t, i2a, i2b)};
            CFG_LOAD = (t == cfg_t);
            RESET    = (t == rst_t);
            if (t == cfg_t || t == rst_t) EXTEND_LEN = {N_CH{LW'(new_l)}};
            step();
            exp = {7'b0, in_rng(t + 1, e1a, e1b) || in_rng(t + 1, e2a, e2b)};
            check($sformatf("%s_out_t%0d", name, t + 1), SIG_OUT, exp);
            check($sformatf("%s_or_t%0d", name, t + 1), {7'b0, SIG_OR}, {7'b0, exp[0]});
        end
        SIG_IN   = '0;
        CFG_LOAD = 1'b0;
        RESET    = 1'b0;
    endtask

    initial begin
        logic [7:0] v;

        // ch0 L=1, others L=0: out(t) = in(t) | in(t-1) on ch0, plain delay elsewhere.
        vec[0]  = '{8'h00, 8'h00, 1'b0};
        vec[1]  = '{8'hA5, 8'hA5, 1'b1};
        vec[2]  = '{8'h5A, 8'h5B, 1'b1};
        vec[3]  = '{8'hFF, 8'hFF, 1'b1};
        vec[4]  = '{8'h00, 8'h01, 1'b1};
        vec[5]  = '{8'h00, 8'h00, 1'b0};
        vec[6]  = '{8'h81, 8'h81, 1'b1};
        vec[7]  = '{8'h80, 8'h81, 1'b1};
        vec[8]  = '{8'h01, 8'h01, 1'b1};
        vec[9]  = '{8'h00, 8'h01, 1'b1};
        vec[10] = '{8'h7E, 8'h7E, 1'b1};
        vec[11] = '{8'h00, 8'h00, 1'b0};

        setup(0, 0, 1'b1);
        EXTEND_LEN = 40'h1;
        CFG_LOAD   = 1'b1;
        step();
        CFG_LOAD   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            SIG_IN = vec[i].sig;
            step();
            check($sformatf("table_out_%0d", i), SIG_OUT, vec[i].exp_out);
            check($sformatf("table_or_%0d", i), {7'b0, SIG_OR}, {7'b0, vec[i].exp_or});
        end

        setup(0, 0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            v = 8'($urandom);
            SIG_IN = v;
            step();
            check($sformatf("delay_out_%0d", i), SIG_OUT, v);
            check($sformatf("delay_or_%0d", i), {7'b0, SIG_OR}, {7'b0, |v});
        end

        setup(4, 0, 1'b1);
        run_seq("single", 10, 0, 0, -1, -2, 1, 5, -1, -2, -1, -1, 0);

        setup(6, 0, 1'b1);
        run_seq("merge", 16, 0, 0, 4, 4, 1, 11, -1, -2, -1, -1, 0);

        setup(6, 3, 1'b0);
        run_seq("fixed", 16, 0, 0, 4, 4, 1, 7, -1, -2, -1, -1, 0);

        setup(31, 31, 1'b0);
        run_seq("allones", 110, 0, 39, 80, 500, 1, 71, 103, 500, -1, -1, 0);

        setup(6, 0, 1'b1);
        run_seq("cfg_entry", 20, 0, 0, 10, 10, 1, 7, 11, 13, 1, -1, 2);

        setup(6, 0, 1'b1);
        run_seq("cfg_hold", 20, 0, 0, 10, 10, 1, 7, 11, 13, 3, -1, 2);

        setup(6, 0, 1'b1);
        run_seq("rst_hold", 16, 0, 0, 8, 8, 1, 3, 9, 12, -1, 3, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
